// File: rtl/half_adder_bist.sv
// Built-in self-test controller for the half_adder cell: applies the four
// exhaustive {a,b} patterns, checks s/c against a golden model and compacts them in a MISR.
module half_adder_bist #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [3:0]  GOLDEN_SIG  = 4'h4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] signature,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] first_fail
);

    localparam int unsigned HOLD_W   = 4;
    localparam int unsigned PAT_W    = 2;
    localparam int unsigned SIG_W    = 4;
    localparam int unsigned ERR_W    = 3;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [PAT_W-1:0]    pat;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                sample_c;
    logic                exp_s_c;
    logic                exp_c_c;
    logic                mismatch_c;
    logic [PAT_W-1:0]    pat_inc_c;
    logic [SIG_W-1:0]    sig_next_c;
    logic [ERR_W-1:0]    err_next_c;

    // Golden model, MISR feedback and error accounting for the pattern on the bus
    always_comb begin
        sample_c   = (state == ST_APPLY) && (hold_cnt == HOLD_LAST);
        exp_s_c    = pat[1] ^ pat[0];
        exp_c_c    = pat[1] & pat[0];
        mismatch_c = (s != exp_s_c) || (c != exp_c_c);
        pat_inc_c  = pat + PAT_W'(1);
        sig_next_c = {signature[2],
                      signature[1],
                      signature[0] ^ signature[3] ^ c,
                      signature[3] ^ s};
        err_next_c = err_count + ERR_W'(mismatch_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pat        <= '0;
            hold_cnt   <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A new run wipes every result so nothing from a prior run leaks through
                    if (start) begin
                        state      <= ST_APPLY;
                        pat        <= '0;
                        hold_cnt   <= '0;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        signature  <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                ST_APPLY: begin
                    if (sample_c) begin
                        hold_cnt  <= '0;
                        signature <= sig_next_c;
                        pat       <= pat_inc_c;
                        if (mismatch_c) begin
                            err_count <= err_next_c;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= pat;
                            end
                        end
                        if (pat == PAT_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == ERR_W'(0)) && (sig_next_c == GOLDEN_SIG);
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            a <= pat_inc_c[1];
                            b <= pat_inc_c[0];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_adder_bist.sv
// Scoreboard bench for half_adder_bist: two instances (hold 1 and hold 3) driving a
// behavioural half adder with injectable stuck-at-0 faults on s and c.
module tb_half_adder_bist;

    typedef struct packed {
        logic [3:0] sig;
        logic [2:0] err;
        logic       fv;
        logic [1:0] ff;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       s_sa0;
    logic       c_sa0;
    logic [1:0] start_v;
    logic [1:0] s_v, c_v, a_v, b_v, busy_v, done_v, pass_v, fv_v;
    logic [3:0] sig_v [2];
    logic [2:0] err_v [2];
    logic [1:0] ff_v  [2];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    int         busy_cnt [2];
    logic [1:0] done_q;
    exp_t       mon_e;
    int         mon_depth;

    half_adder_bist #(.HOLD_CYCLES(1), .GOLDEN_SIG(4'h4)) u_h1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .s(s_v[0]), .c(c_v[0]),
        .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .signature(sig_v[0]), .err_count(err_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
    );

    half_adder_bist #(.HOLD_CYCLES(3), .GOLDEN_SIG(4'h4)) u_h3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .s(s_v[1]), .c(c_v[1]),
        .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .err_count(err_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
    );

    // Cell under test with optional stuck-at-0 faults
    assign s_v[0] = (a_v[0] ^ b_v[0]) & ~s_sa0;
    assign c_v[0] = (a_v[0] & b_v[0]) & ~c_sa0;
    assign s_v[1] = (a_v[1] ^ b_v[1]) & ~s_sa0;
    assign c_v[1] = (a_v[1] & b_v[1]) & ~c_sa0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_reset(input int i, input string tag);
        check({tag, "_a"},          a_v[i],    0);
        check({tag, "_b"},          b_v[i],    0);
        check({tag, "_busy"},       busy_v[i], 0);
        check({tag, "_done"},       done_v[i], 0);
        check({tag, "_pass"},       pass_v[i], 0);
        check({tag, "_signature"},  sig_v[i],  0);
        check({tag, "_err_count"},  err_v[i],  0);
        check({tag, "_fail_valid"}, fv_v[i],   0);
        check({tag, "_first_fail"}, ff_v[i],   0);
    endtask

    // Monitor: pattern sequence while busy, scoreboard pop on each rising done
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy_cnt[i] = 0;
                done_q[i]   = 1'b0;
            end else begin
                if (busy_v[i]) begin
                    check("pattern_ab", int'({a_v[i], b_v[i]}), busy_cnt[i] / hold_of(i));
                    busy_cnt[i]++;
                end
                if (done_v[i] && !done_q[i]) begin
                    mon_depth = (i == 0) ? sb0.size() : sb1.size();
                    check("sb_depth", (mon_depth > 0) ? 1 : 0, 1);
                    if (mon_depth > 0) begin
                        if (i == 0) mon_e = sb0.pop_front();
                        else        mon_e = sb1.pop_front();
                        check("signature",  sig_v[i], mon_e.sig);
                        check("err_count",  err_v[i], mon_e.err);
                        check("fail_valid", fv_v[i],  mon_e.fv);
                        check("first_fail", ff_v[i],  mon_e.ff);
                        check("pass",       pass_v[i], mon_e.pass);
                        check("busy_cycles", busy_cnt[i], 4 * hold_of(i));
                        check("done_ab", int'({a_v[i], b_v[i]}), 0);
                    end
                    busy_cnt[i] = 0;
                end
                done_q[i] = done_v[i];
            end
        end
    end

    // Single start pulse, optional start pulse mid-run, then bounded wait for done
    task automatic run(input int i, input exp_t e, input int exp_lat, input bit mid_pulse);
        int edges;
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
        edges = 1;
        while (!done_v[i] && edges < 400) begin
            @(negedge clk);
            edges++;
            start_v[i] = (mid_pulse && edges == 4);
        end
        start_v[i] = 1'b0;
        check("done_latency", edges, exp_lat);
        @(negedge clk);
        check("done_hold", done_v[i], 1);
    endtask

    task automatic wait_done(input int i, output int edges);
        edges = 1;
        @(negedge clk);
        while (!done_v[i] && edges < 400) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int edges;
        rst     = 1'b1;
        start_v = 2'b00;
        s_sa0   = 1'b0;
        c_sa0   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset(0, "reset_h1");
        check_reset(1, "reset_h3");
        rst = 1'b0;
        @(negedge clk);

        // Fault-free, stuck s, stuck c with hold 1
        run(0, '{sig: 4'h4, err: 3'd0, fv: 1'b0, ff: 2'b00, pass: 1'b1}, 5, 1'b0);
        s_sa0 = 1'b1;
        run(0, '{sig: 4'h2, err: 3'd2, fv: 1'b1, ff: 2'b01, pass: 1'b0}, 5, 1'b0);
        s_sa0 = 1'b0;
        c_sa0 = 1'b1;
        run(0, '{sig: 4'h6, err: 3'd1, fv: 1'b1, ff: 2'b11, pass: 1'b0}, 5, 1'b0);
        c_sa0 = 1'b0;

        // Hold 3 with a start pulse in the middle of the run
        run(1, '{sig: 4'h4, err: 3'd0, fv: 1'b0, ff: 2'b00, pass: 1'b1}, 13, 1'b1);

        // Reset during the third pattern, then a clean run
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_third_pattern", int'({a_v[0], b_v[0]}), 2);
        #2 rst = 1'b1;
        #1 check_reset(0, "abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(0, '{sig: 4'h4, err: 3'd0, fv: 1'b0, ff: 2'b00, pass: 1'b1}, 5, 1'b0);

        // Back-to-back: faulty run, then fault-free run with start held high
        s_sa0 = 1'b1;
        sb0.push_back('{sig: 4'h2, err: 3'd2, fv: 1'b1, ff: 2'b01, pass: 1'b0});
        sb0.push_back('{sig: 4'h4, err: 3'd0, fv: 1'b0, ff: 2'b00, pass: 1'b1});
        @(negedge clk); start_v[0] = 1'b1;
        wait_done(0, edges);
        check("b2b_first_latency", edges, 5);
        s_sa0 = 1'b0;
        @(negedge clk);
        check("b2b_done_pulse", done_v[0], 0);
        check("b2b_busy",       busy_v[0], 1);
        check("b2b_sig_clear",  sig_v[0],  0);
        check("b2b_err_clear",  err_v[0],  0);
        check("b2b_fv_clear",   fv_v[0],   0);
        check("b2b_ff_clear",   ff_v[0],   0);
        edges = 1;
        while (!done_v[0] && edges < 400) begin
            @(negedge clk);
            edges++;
        end
        start_v[0] = 1'b0;
        check("b2b_second_latency", edges, 5);
        @(negedge clk);
        check("b2b_done_hold", done_v[0], 1);

        repeat (2) @(negedge clk);
        check("sb0_leftover", sb0.size(), 0);
        check("sb1_leftover", sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
